// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width, baud divider helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Clocks per oversample tick, truncated and never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-cycle tick every DIV clocks.
// Latency: first tick DIV-1 clocks after reset release (every clock when DIV=1).
// Backpressure: none; the tick never stalls.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk_bus,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_cpld_responder.sv
// CPLD UART responder: strobe-driven 8N1 TX with one holding byte, RX into a holding byte; UART_LOOPBACK_EN routes TX into RX.
// Latency: write to start bit <= DIV+2 clocks when idle; RX stop sample to cpld_tready one clock.
// Backpressure: none; a write while the TX holding register is full is dropped, RX overrun overwrites.
module uart_cpld_responder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_bus,
  input  logic       rst,
  input  logic       cpld_wrn,
  input  logic       cpld_rdn,
  input  logic [7:0] cpld_data_i,
  output logic [7:0] cpld_data_o,
  output logic       cpld_tsre,
  output logic       cpld_tready,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk_bus (clk_bus),
    .rst     (rst),
    .tick    (tick)
  );

  logic wrn_q, rdn_q;
  logic wr_evt, rd_done;

  assign wr_evt  = wrn_q & ~cpld_wrn;
  assign rd_done = ~rdn_q & cpld_rdn;

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= cpld_wrn;
      rdn_q <= cpld_rdn;
    end
  end

  logic [DATA_BITS-1:0] thr, tx_shr;
  logic                 thr_full;
  logic [1:0]           tx_state;
  logic [OSW-1:0]       tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic                 tx_line;
  logic                 tx_load;

  // Holding register drains into the shifter from IDLE or straight out of STOP.
  assign tx_load = thr_full && tick &&
                   ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_cnt == OS_LAST)));

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      thr       <= '0;
      thr_full  <= 1'b0;
      cpld_tsre <= 1'b1;
    end else begin
      if (wr_evt && !thr_full) begin
        thr      <= cpld_data_i;
        thr_full <= 1'b1;
      end else if (tx_load) begin
        thr_full <= 1'b0;
      end
      cpld_tsre <= (tx_state == ST_IDLE) && !thr_full;
    end
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shr   <= '0;
      tx_line  <= 1'b1;
    end else if (tx_load) begin
      tx_shr   <= thr;
      tx_cnt   <= '0;
      tx_line  <= 1'b0;
      tx_state <= ST_START;
    end else if (tick && tx_state != ST_IDLE) begin
      if (tx_cnt != OS_LAST) begin
        tx_cnt <= tx_cnt + OSW'(1);
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          ST_START: begin
            tx_bit   <= '0;
            tx_line  <= tx_shr[0];
            tx_state <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_bit == BIT_LAST) begin
              tx_line  <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx_bit  <= tx_bit + BW'(1);
              tx_line <= tx_shr[1];
              tx_shr  <= tx_shr >> 1;
            end
          end
          default: begin
            tx_line  <= 1'b1;
            tx_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  logic rx_src;

`ifdef UART_LOOPBACK_EN
  assign rx_src   = tx_line;
  assign uart_txd = 1'b1;
`else
  assign rx_src   = uart_rxd;
  assign uart_txd = tx_line;
`endif

  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev;
  logic [1:0]           rx_state;
  logic [OSW-1:0]       rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shr, rhr;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      rx_sync     <= 2'b11;
      rx_prev     <= 1'b1;
      rx_state    <= ST_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shr      <= '0;
      rhr         <= '0;
      cpld_tready <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_src};
      rx_prev <= rx_s;
      // A load later in this block overrides the read-done clear.
      if (rd_done) cpld_tready <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt   <= '0;
              rx_bit   <= '0;
              rx_state <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt <= rx_cnt + OSW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (rx_cnt == OS_LAST) begin
              rx_cnt <= '0;
              rx_shr <= {rx_s, rx_shr[DATA_BITS-1:1]};
              if (rx_bit == BIT_LAST) rx_state <= ST_STOP;
              else                    rx_bit   <= rx_bit + BW'(1);
            end else begin
              rx_cnt <= rx_cnt + OSW'(1);
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_cnt == OS_LAST) begin
              rx_cnt   <= '0;
              rx_state <= ST_IDLE;
              if (rx_s) begin
                rhr         <= rx_shr;
                cpld_tready <= 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + OSW'(1);
            end
          end
        end
      endcase
    end
  end

  assign cpld_data_o = cpld_rdn ? 8'h00 : rhr;

endmodule
